// File: rtl/word_tokenizer.sv
// word_tokenizer
//   Front end of the keyword nesting checker. Groups a byte stream into
//   whitespace-delimited words and classifies each one, case-insensitively,
//   as BEGIN, END or OTHER. One registered token (kind + saturating length)
//   is emitted per completed word.
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   in_valid, in      one ASCII byte consumed per valid cycle
//   flush             end of stream; closes any open word
//   tok_valid         one-cycle pulse, token on tok_kind/tok_len
//   tok_kind          00 OTHER, 01 BEGIN, 10 END
//   tok_len           word length, saturating at all-ones
//   tok_count         tokens emitted since reset, wrapping
//   in_word           high while a word is open
module word_tokenizer #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in,
  input  logic             flush,
  output logic             tok_valid,
  output logic [1:0]       tok_kind,
  output logic [LEN_W-1:0] tok_len,
  output logic [CNT_W-1:0] tok_count,
  output logic             in_word
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] S_B     = 4'd1;
  localparam logic [3:0] S_BE    = 4'd2;
  localparam logic [3:0] S_BEG   = 4'd3;
  localparam logic [3:0] S_BEGI  = 4'd4;
  localparam logic [3:0] S_BEGIN = 4'd5;
  localparam logic [3:0] S_E     = 4'd6;
  localparam logic [3:0] S_EN    = 4'd7;
  localparam logic [3:0] S_END   = 4'd8;
  localparam logic [3:0] S_OTHER = 4'd9;

  localparam logic [1:0] K_OTHER = 2'b00;
  localparam logic [1:0] K_BEGIN = 2'b01;
  localparam logic [1:0] K_END   = 2'b10;

  logic [3:0]       state, state_d;
  logic [LEN_W-1:0] len_q;

  logic [7:0]       lc;
  logic             is_delim, take_char, take_delim, emit;
  logic [3:0]       char_st, word_st;
  logic [LEN_W-1:0] char_len, word_len;
  logic [1:0]       kind_d;

  always_comb begin
    // OR-ing 0x20 folds upper case onto lower case; only the two case
    // variants of a letter map onto the same lowercase code.
    lc         = in | 8'h20;
    is_delim   = (in == 8'h20) || (in == 8'h09) || (in == 8'h0A) || (in == 8'h0D);
    take_char  = in_valid && !is_delim;
    take_delim = in_valid && is_delim;

    char_st = S_OTHER;
    case (state)
      IDLE:   char_st = (lc == 8'h62) ? S_B : (lc == 8'h65) ? S_E : S_OTHER;
      S_B:    char_st = (lc == 8'h65) ? S_BE    : S_OTHER;
      S_BE:   char_st = (lc == 8'h67) ? S_BEG   : S_OTHER;
      S_BEG:  char_st = (lc == 8'h69) ? S_BEGI  : S_OTHER;
      S_BEGI: char_st = (lc == 8'h6E) ? S_BEGIN : S_OTHER;
      S_E:    char_st = (lc == 8'h6E) ? S_EN    : S_OTHER;
      S_EN:   char_st = (lc == 8'h64) ? S_END   : S_OTHER;
      default: char_st = S_OTHER;
    endcase

    if (state == IDLE)     char_len = LEN_W'(1);
    else if (&len_q)       char_len = len_q;
    else                   char_len = len_q + LEN_W'(1);

    // The word as it stands after this cycle's byte. A delimiter leaves it
    // untouched, so a same-cycle flush closes the same word, once.
    word_st  = take_char ? char_st  : state;
    word_len = take_char ? char_len : len_q;

    emit    = (word_st != IDLE) && (take_delim || flush);
    state_d = (emit || take_delim) ? IDLE : word_st;

    case (word_st)
      S_BEGIN: kind_d = K_BEGIN;
      S_END:   kind_d = K_END;
      default: kind_d = K_OTHER;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= '0;
      tok_valid <= 1'b0;
      tok_kind  <= K_OTHER;
      tok_len   <= '0;
      tok_count <= '0;
    end else begin
      state     <= state_d;
      len_q     <= word_len;
      tok_valid <= emit;
      if (emit) begin
        tok_kind  <= kind_d;
        tok_len   <= word_len;
        tok_count <= tok_count + CNT_W'(1);
      end
    end
  end

  assign in_word = (state != IDLE);

endmodule

// File: tb/tb_word_tokenizer.sv
module tb_word_tokenizer;
  localparam int LEN_W = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in;
  logic             flush;
  logic             tok_valid;
  logic [1:0]       tok_kind;
  logic [LEN_W-1:0] tok_len;
  logic [CNT_W-1:0] tok_count;
  logic             in_word;

  word_tokenizer #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .flush(flush),
    .tok_valid(tok_valid), .tok_kind(tok_kind), .tok_len(tok_len),
    .tok_count(tok_count), .in_word(in_word)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the open word is kept as a byte queue and classified
  // as a whole string when it closes.
  logic [7:0] q[$];
  int e_valid, e_kind, e_len, e_count, e_inword;

  int got_kind[$];
  int got_len[$];

  function automatic bit is_delim(logic [7:0] c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
  endfunction

  function automatic bit word_is(string kw);
    if (q.size() != kw.len()) return 0;
    for (int i = 0; i < kw.len(); i++)
      if ((q[i] | 8'h20) != 8'(kw[i])) return 0;
    return 1;
  endfunction

  task automatic model_step(bit inv, logic [7:0] ch, bit fl);
    bit em = 0;
    if (inv) begin
      if (is_delim(ch)) em = (q.size() > 0);
      else              q.push_back(ch);
    end
    if (fl && q.size() > 0) em = 1;
    e_valid = em;
    if (em) begin
      e_kind  = word_is("begin") ? 1 : word_is("end") ? 2 : 0;
      e_len   = (q.size() > 255) ? 255 : q.size();
      e_count = (e_count + 1) % (1 << CNT_W);
      q.delete();
    end
    e_inword = (q.size() > 0);
  endtask

  task automatic check_outs(string nm);
    checks++;
    if (tok_valid !== 1'(e_valid) || tok_kind !== 2'(e_kind) || tok_len !== LEN_W'(e_len) ||
        tok_count !== CNT_W'(e_count) || in_word !== 1'(e_inword)) begin
      errors++;
      $display("FAIL %s: got v=%0d k=%0d len=%0d cnt=%0d w=%0d, want v=%0d k=%0d len=%0d cnt=%0d w=%0d",
               nm, tok_valid, tok_kind, tok_len, tok_count, in_word,
               e_valid, e_kind, e_len, e_count, e_inword);
    end
  endtask

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(bit inv, logic [7:0] ch, bit fl, string nm);
    in_valid = inv; in = ch; flush = fl;
    @(posedge clk);
    model_step(inv, ch, fl);
    #1;
    check_outs(nm);
    if (tok_valid) begin
      got_kind.push_back(int'(tok_kind));
      got_len.push_back(int'(tok_len));
    end
    in_valid = 0; flush = 0;
  endtask

  task automatic feed(string s, bit fl_last, string nm);
    for (int i = 0; i < s.len(); i++)
      cyc(1'b1, 8'(s[i]), fl_last && (i == s.len() - 1), nm);
  endtask

  task automatic do_reset(string nm);
    reset = 1'b1;
    #1;
    q.delete();
    e_valid = 0; e_kind = 0; e_len = 0; e_count = 0; e_inword = 0;
    check_outs(nm);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_toks(string nm, int n, int k0, int l0, int k1, int l1);
    chk({nm, " ntok"}, got_kind.size(), n);
    if (got_kind.size() == n && n > 0) begin
      chk({nm, " kind0"}, got_kind[0], k0);
      chk({nm, " len0"},  got_len[0],  l0);
      chk({nm, " kindN"}, got_kind[n-1], k1);
      chk({nm, " lenN"},  got_len[n-1],  l1);
    end
  endtask

  typedef struct {
    string txt;
    bit    fl_last;
    int    ntok;
    int    k0, l0, k1, l1;
  } vec_t;

  initial begin
    vec_t vecs[$];
    string words[$];
    string pool;

    vecs.push_back('{"BEGIN ",         0, 1, 1, 5, 1, 5});
    vecs.push_back('{"eNd\tbegin ",    0, 2, 2, 3, 1, 5});
    vecs.push_back('{"beginx  en  ",   0, 2, 0, 6, 0, 2});
    vecs.push_back('{"END",            1, 1, 2, 3, 2, 3});
    vecs.push_back('{"BEG\n",          0, 1, 0, 3, 0, 3});
    vecs.push_back('{"ends\r",         0, 1, 0, 4, 0, 4});
    vecs.push_back('{"a b ",           0, 2, 0, 1, 0, 1});
    vecs.push_back('{"xEnD \t\r\n",    0, 1, 0, 4, 0, 4});
    vecs.push_back('{"bEgIn",          1, 1, 1, 5, 1, 5});

    in_valid = 0; in = 8'h00; flush = 0;
    do_reset("reset state");

    foreach (vecs[v]) begin
      got_kind.delete(); got_len.delete();
      feed(vecs[v].txt, vecs[v].fl_last, $sformatf("vec%0d", v));
      chk_toks($sformatf("vec%0d", v), vecs[v].ntok,
               vecs[v].k0, vecs[v].l0, vecs[v].k1, vecs[v].l1);
    end

    // flush with nothing open: no token
    got_kind.delete(); got_len.delete();
    cyc(1'b0, 8'h00, 1'b1, "idle flush");
    chk_toks("idle flush", 0, 0, 0, 0, 0);

    // flush alone closes an open word
    got_kind.delete(); got_len.delete();
    feed("begin", 0, "flush alone");
    cyc(1'b0, 8'h00, 1'b1, "flush alone");
    chk_toks("flush alone", 1, 1, 5, 1, 5);

    // delimiter and flush together: one token only
    got_kind.delete(); got_len.delete();
    feed("end", 0, "delim+flush");
    cyc(1'b1, 8'h20, 1'b1, "delim+flush");
    cyc(1'b0, 8'h00, 1'b0, "delim+flush");
    chk_toks("delim+flush", 1, 2, 3, 2, 3);

    // long word saturates the length
    got_kind.delete(); got_len.delete();
    repeat (300) cyc(1'b1, 8'h61, 1'b0, "long word");
    cyc(1'b1, 8'h20, 1'b0, "long word");
    chk_toks("long word", 1, 0, 255, 0, 255);

    // reset mid-word discards it
    feed("BEG", 0, "pre-reset");
    do_reset("mid-word reset");
    got_kind.delete(); got_len.delete();
    feed("END ", 0, "post-reset");
    chk_toks("post-reset", 1, 2, 3, 2, 3);
    chk("post-reset count", int'(tok_count), 1);

    // in_valid low mid-word holds everything
    got_kind.delete(); got_len.delete();
    feed("EN", 0, "hold");
    repeat (5) cyc(1'b0, 8'h78, 1'b0, "hold");
    feed("D ", 0, "hold");
    chk_toks("hold", 1, 2, 3, 2, 3);

    // tok_count wraps at 2**CNT_W
    do_reset("wrap reset");
    repeat (17) feed("a ", 0, "wrap");
    chk("wrap count", int'(tok_count), 1);

    // randomized words with gaps, delimiter runs and flushes
    words = '{"begin", "BeGiN", "end", "EnD", "beg", "en", "beginx", "x", "e", "b", "ends", "BEGI"};
    pool  = {"abeginxdBEGIND@", string'(8'h60)};
    for (int w = 0; w < 400; w++) begin
      string s;
      bit    use_fl;
      if ($urandom_range(0, 2) != 0) s = words[$urandom_range(0, words.size() - 1)];
      else begin
        s = "";
        for (int i = 0; i < int'($urandom_range(1, 7)); i++)
          s = {s, string'(pool[$urandom_range(0, pool.len() - 1)])};
      end
      use_fl = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < s.len(); i++) begin
        while ($urandom_range(0, 4) == 0)
          cyc(1'b0, 8'($urandom), ($urandom_range(0, 29) == 0), "rand gap");
        cyc(1'b1, 8'(s[i]), use_fl && (i == s.len() - 1), "rand char");
      end
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
        logic [7:0] dl;
        case ($urandom_range(0, 3))
          0: dl = 8'h20;
          1: dl = 8'h09;
          2: dl = 8'h0A;
          default: dl = 8'h0D;
        endcase
        cyc(1'b1, dl, ($urandom_range(0, 9) == 0), "rand delim");
      end
      if (w == 200) do_reset("rand reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
